// File: rtl/hypot_sqrt_unit.sv
// hypot_sqrt_unit: integer sqrt of x^2+y^2(+z^2), one result bit per cycle.
// Floor or round-to-nearest result with a perfect-square flag.
module hypot_sqrt_unit #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         ena,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] x,
  input  logic [W-1:0] y,
  input  logic [W-1:0] z,
  input  logic         mode_3d,
  input  logic         round_en,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W:0]   root,
  output logic         exact
);

  localparam int SW = 2 * W + 2;
  localparam int RW = W + 2;
  localparam int CW = $clog2(W + 1);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    ROUND,
    DONE
  } state_t;

  state_t        state;
  logic [SW-1:0] s;
  logic [SW-1:0] sum;
  logic [W:0]    r;
  logic [RW-1:0] rem;
  logic [RW-1:0] rem_nx;
  logic [CW-1:0] i;
  logic          rnd;
  logic [W+3:0]  cand;
  logic [W+3:0]  trial;
  logic          fits;

  assign in_ready = (state == IDLE) && ena;

  assign sum = SW'(x) * SW'(x)
             + SW'(y) * SW'(y)
             + (mode_3d ? SW'(z) * SW'(z) : '0);

  // s is consumed two bits per step from the top; rem stays S' - r^2
  assign cand   = {rem, s[SW-1 -: 2]};
  assign trial  = {1'b0, r, 2'b01};
  assign fits   = cand >= trial;
  assign rem_nx = fits ? RW'(cand - trial) : cand[RW-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      out_valid <= 1'b0;
      root      <= '0;
      exact     <= 1'b0;
      s         <= '0;
      r         <= '0;
      rem       <= '0;
      i         <= '0;
      rnd       <= 1'b0;
    end else if (ena) begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            s     <= sum;
            rnd   <= round_en;
            r     <= '0;
            rem   <= '0;
            i     <= CW'(W);
            state <= CALC;
          end
        end
        CALC: begin
          rem <= rem_nx;
          r   <= {r[W-1:0], fits};
          s   <= {s[SW-3:0], 2'b00};
          if (i == '0) state <= ROUND;
          else i <= i - CW'(1);
        end
        ROUND: begin
          exact     <= (rem == '0);
          root      <= (rnd && rem > RW'(r))
                     ? r + (W+1)'(1) : r;
          out_valid <= 1'b1;
          state     <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hypot_sqrt_unit.sv
// tb_hypot_sqrt_unit: scoreboard bench for hypot_sqrt_unit.
// Main checks at W=8, random sweeps at W=4 and W=12.
module tb_hypot_sqrt_unit;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic ena = 1'b1;
  logic out_ready = 1'b1;
  logic mode_3d = 1'b0;
  logic round_en = 1'b0;

  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] x = '0, y = '0, z = '0;
  logic       out_valid;
  logic [8:0] root;
  logic       exact;

  logic       in_valid_a = 1'b0;
  logic       in_ready_a;
  logic [3:0] xa = '0, ya = '0, za = '0;
  logic       out_valid_a;
  logic [4:0] root_a;
  logic       exact_a;

  logic        in_valid_b = 1'b0;
  logic        in_ready_b;
  logic [11:0] xb = '0, yb = '0, zb = '0;
  logic        out_valid_b;
  logic [12:0] root_b;
  logic        exact_b;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int acc_cyc = 0, hs_cyc = 0, exp_lat = 10;
  int acc_a = 0, acc_b = 0;
  bit b2b_chk = 0;
  bit ov_q = 0, ovq_a = 0, ovq_b = 0;
  logic [16:0] sb[$];
  logic [16:0] qa[$];
  logic [16:0] qb[$];

  hypot_sqrt_unit #(.W(8)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena),
    .in_valid(in_valid), .in_ready(in_ready),
    .x(x), .y(y), .z(z),
    .mode_3d(mode_3d), .round_en(round_en),
    .out_valid(out_valid), .out_ready(out_ready),
    .root(root), .exact(exact)
  );

  hypot_sqrt_unit #(.W(4)) dut_a (
    .clk(clk), .rst_n(rst_n), .ena(ena),
    .in_valid(in_valid_a), .in_ready(in_ready_a),
    .x(xa), .y(ya), .z(za),
    .mode_3d(mode_3d), .round_en(round_en),
    .out_valid(out_valid_a), .out_ready(out_ready),
    .root(root_a), .exact(exact_a)
  );

  hypot_sqrt_unit #(.W(12)) dut_b (
    .clk(clk), .rst_n(rst_n), .ena(ena),
    .in_valid(in_valid_b), .in_ready(in_ready_b),
    .x(xb), .y(yb), .z(zb),
    .mode_3d(mode_3d), .round_en(round_en),
    .out_valid(out_valid_b), .out_ready(out_ready),
    .root(root_b), .exact(exact_b)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", tag, got, exp);
    end
  endtask

  function automatic longint sumsq(input int a, input int b,
                                   input int c, input bit m);
    return longint'(a) * a + longint'(b) * b
         + (m ? longint'(c) * c : 64'd0);
  endfunction

  // reference: linear search for floor root, nearest via (2r+1)^2 < 4S
  function automatic logic [16:0] model(input longint s, input bit rd);
    longint r;
    logic ex;
    r = 0;
    while ((r + 1) * (r + 1) <= s) r++;
    ex = (r * r == s);
    if (rd && 4 * s > (2 * r + 1) * (2 * r + 1)) r++;
    return {ex, 16'(r)};
  endfunction

  always @(negedge clk) begin
    logic [16:0] e;
    if (rst_n && in_valid && in_ready) begin
      if (b2b_chk) begin
        chk("b2b_accept", 32'(cyc + 1), 32'(hs_cyc + 1));
        b2b_chk = 0;
      end
      acc_cyc = cyc + 1;
    end
    if (rst_n && out_valid && !ov_q)
      chk("latency", 32'(cyc - acc_cyc), 32'(exp_lat));
    if (rst_n && out_valid && out_ready && ena) begin
      if (sb.size() == 0) chk("spurious", 1, 0);
      else begin
        e = sb.pop_front();
        chk("root", 32'(root), 32'(e[15:0]));
        chk("exact", 32'(exact), 32'(e[16]));
      end
      hs_cyc = cyc + 1;
    end
    ov_q = out_valid;
  end

  always @(negedge clk) begin
    logic [16:0] e;
    if (rst_n && in_valid_a && in_ready_a) acc_a = cyc + 1;
    if (rst_n && out_valid_a && !ovq_a)
      chk("lat_w4", 32'(cyc - acc_a), 6);
    if (rst_n && out_valid_a && out_ready && ena) begin
      if (qa.size() == 0) chk("spur_w4", 1, 0);
      else begin
        e = qa.pop_front();
        chk("root_w4", 32'(root_a), 32'(e[15:0]));
        chk("exact_w4", 32'(exact_a), 32'(e[16]));
      end
    end
    ovq_a = out_valid_a;
  end

  always @(negedge clk) begin
    logic [16:0] e;
    if (rst_n && in_valid_b && in_ready_b) acc_b = cyc + 1;
    if (rst_n && out_valid_b && !ovq_b)
      chk("lat_w12", 32'(cyc - acc_b), 14);
    if (rst_n && out_valid_b && out_ready && ena) begin
      if (qb.size() == 0) chk("spur_w12", 1, 0);
      else begin
        e = qb.pop_front();
        chk("root_w12", 32'(root_b), 32'(e[15:0]));
        chk("exact_w12", 32'(exact_b), 32'(e[16]));
      end
    end
    ovq_b = out_valid_b;
  end

  task automatic req(input int a, input int b, input int c,
                     input bit m, input bit rd, input bit hold);
    bit ok;
    @(posedge clk);
    #1;
    x = 8'(a); y = 8'(b); z = 8'(c);
    mode_3d = m; round_en = rd; in_valid = 1'b1;
    sb.push_back(model(sumsq(a, b, c, m), rd));
    ok = 0;
    for (int n = 0; n < 100 && !ok; n++) begin
      @(negedge clk);
      ok = in_ready;
    end
    chk("accept", 32'(ok), 1);
    @(posedge clk);
    #1;
    if (!hold) in_valid = 1'b0;
  endtask

  task automatic sreq(input int w, input int a, input int b,
                      input int c, input bit m, input bit rd);
    bit ok;
    @(posedge clk);
    #1;
    mode_3d = m; round_en = rd;
    if (w == 4) begin
      xa = 4'(a); ya = 4'(b); za = 4'(c); in_valid_a = 1'b1;
      qa.push_back(model(sumsq(a, b, c, m), rd));
    end else begin
      xb = 12'(a); yb = 12'(b); zb = 12'(c); in_valid_b = 1'b1;
      qb.push_back(model(sumsq(a, b, c, m), rd));
    end
    ok = 0;
    for (int n = 0; n < 100 && !ok; n++) begin
      @(negedge clk);
      ok = (w == 4) ? in_ready_a : in_ready_b;
    end
    chk("s_accept", 32'(ok), 1);
    @(posedge clk);
    #1;
    in_valid_a = 1'b0;
    in_valid_b = 1'b0;
  endtask

  task automatic drain();
    for (int n = 0; n < 300; n++) begin
      if (sb.size() == 0 && qa.size() == 0 && qb.size() == 0) break;
      @(negedge clk);
    end
    chk("drain", 32'(sb.size() + qa.size() + qb.size()), 0);
  endtask

  int ta[10] = '{3, 255, 255, 255, 255, 255, 255, 0, 1, 0};
  int tb_[10] = '{4, 255, 255, 255, 255, 255, 255, 0, 1, 255};
  int tc[10] = '{0, 0, 0, 255, 255, 255, 255, 0, 0, 0};
  bit tm[10] = '{0, 0, 0, 1, 1, 0, 0, 0, 0, 0};
  bit tr[10] = '{0, 0, 1, 0, 1, 0, 1, 0, 1, 0};

  initial begin
    logic [8:0] r0;
    logic e0;
    bit seen;
    #2 rst_n = 1'b0;
    #3;
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_root", 32'(root), 0);
    chk("rst_exact", 32'(exact), 0);
    chk("rst_in_ready", 32'(in_ready), 1);
    ena = 1'b0;
    #1 chk("in_ready_ena0", 32'(in_ready), 0);
    ena = 1'b1;
    @(posedge clk);
    #1 rst_n = 1'b1;

    for (int k = 0; k < 10; k++)
      req(ta[k], tb_[k], tc[k], tm[k], tr[k], 0);
    drain();

    // backpressure: result held while out_ready is low
    out_ready = 1'b0;
    req(6, 8, 0, 0, 0, 0);
    seen = 0;
    for (int n = 0; n < 40 && !seen; n++) begin
      @(negedge clk);
      seen = out_valid;
    end
    chk("hold_seen", 32'(seen), 1);
    r0 = root;
    e0 = exact;
    for (int n = 0; n < 6; n++) begin
      @(negedge clk);
      chk("hold_root", 32'(root), 32'(r0));
      chk("hold_exact", 32'(exact), 32'(e0));
      chk("hold_valid", 32'(out_valid), 1);
      chk("hold_in_ready", 32'(in_ready), 0);
    end
    @(posedge clk);
    #1 out_ready = 1'b1;
    drain();

    req(5, 12, 0, 0, 0, 1);
    b2b_chk = 1;
    req(8, 15, 0, 0, 0, 0);
    drain();
    chk("b2b_done", 32'(b2b_chk), 0);

    exp_lat = 14;
    req(7, 24, 0, 0, 1, 0);
    repeat (3) @(posedge clk);
    #1 ena = 1'b0;
    repeat (4) @(posedge clk);
    #1 ena = 1'b1;
    drain();
    exp_lat = 10;

    // reset while CALC is at i=3
    req(3, 4, 0, 0, 0, 0);
    repeat (5) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(out_valid), 0);
    chk("mid_rst_root", 32'(root), 0);
    chk("mid_rst_exact", 32'(exact), 0);
    sb.delete();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    for (int n = 0; n < 12; n++) begin
      @(negedge clk);
      chk("no_stale_valid", 32'(out_valid), 0);
    end
    req(3, 4, 0, 0, 0, 0);
    drain();

    for (int n = 0; n < 16; n++)
      sreq(4, $urandom_range(0, 15), $urandom_range(0, 15),
           $urandom_range(0, 15), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)));
    sreq(4, 15, 15, 15, 1, 1);
    drain();
    for (int n = 0; n < 16; n++)
      sreq(12, $urandom_range(0, 4095), $urandom_range(0, 4095),
           $urandom_range(0, 4095), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)));
    sreq(12, 4095, 4095, 4095, 1, 1);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/hypot_sqrt_unit.md
# hypot_sqrt_unit

Parametrised magnitude engine. Computes the integer square root of x²+y² (2-D mode) or x²+y²+z² (3-D mode), with floor or round-to-nearest result and an exact-root flag. It is the next-generation Pythagoras datapath: a generic width W, valid/ready handshakes on both sides, a global freeze enable, and a bit-serial restoring square root that resolves one result bit per cycle.

## Interface
- W, default 8: operand width in bits, W ≥ 2. The sum is 2W+2 bits wide and the result is W+1 bits wide.
- clk  input  1  rising-edge clock for all state.
- rst_n  input  1  asynchronous, active-low reset.
- ena  input  1  global enable. When low, all state and outputs freeze.
- in_valid  input  1  operand set offered.
- in_ready  output  1  unit accepts an operand set. Combinational: (state==IDLE) && ena.
- x, y, z  input  W each  unsigned operands.
- mode_3d  input  1  1 = include z², 0 = ignore z.
- round_en  input  1  1 = round-to-nearest, 0 = floor.
- out_valid  output  1  result available.
- out_ready  input  1  consumer takes the result.
- root  output  W+1  magnitude result.
- exact  output  1  1 when the sum is a perfect square.

## Operation
- Accept occurs on the edge where in_valid && in_ready. On that edge the unit:
  - registers S = x² + y² + (mode_3d ? z² : 0), zero-extended to 2W+2 bits;
  - registers round_en;
  - clears the partial root and remainder;
  - sets bit index i = W;
  - moves to CALC.
- States are IDLE → CALC → ROUND → DONE → IDLE.
- CALC runs exactly W+1 cycles, for i = W down to 0. Each cycle sets result bit i iff (r | 2^i)² ≤ S. Use the restoring remainder form, with no full multiplier per step. After i = 0, go to ROUND.
- In ROUND, with r = floor root and rem = S − r²:
  - exact = (rem == 0);
  - root = r + 1 if round_en && rem > r, else root = r.
  - Registers load, out_valid rises, state goes to DONE.
- Overflow is impossible. Max 3-D root at W=8 is 441, or 442 after rounding. In general √3·(2^W−1)+1 < 2^(W+1).
- In DONE, root, exact and out_valid are held stable until out_ready is high on an edge. That edge clears out_valid and returns to IDLE.
- in_ready is low in CALC, ROUND and DONE. A new operand set is accepted no earlier than the edge after the completing handshake.
- Inputs x, y, z, mode_3d and round_en are don't-care except on the accept edge.
- ena low: no state advances, no accept, no output handshake completes (out_ready is ignored), and outputs hold. Operation resumes exactly where it stopped.

## Timing
- Reset values (asynchronous, immediate on rst_n low): state = IDLE, out_valid = 0, root = 0, exact = 0, S = 0, r = 0, rem = 0, i = 0. in_ready then equals ena.
- Reset asserted mid-CALC, ROUND or DONE: the in-flight result is discarded, no out_valid pulse occurs, and the unit is in IDLE after release.
- Latency with ena held high: accept edge k → out_valid high after edge k+W+2. That is W+2 cycles, 10 at W=8.
- Throughput without backpressure: one result per W+4 cycles (accept, W+1 CALC, ROUND, DONE-handshake cycle, IDLE).
- out_valid, root and exact are registered outputs. in_ready is the only combinational output.
- The partial root, remainder and S are internal and never visible on the ports.

## Test plan
- W=8, 2-D, x=3, y=4, round_en=0 → root=5, exact=1. out_valid rises exactly 10 cycles after the accept edge.
- W=8, 2-D, x=y=255 (S=130050): round_en=0 → root=360, exact=0. round_en=1 → root=361 (rem=450 > 360).
- W=8, 3-D, x=y=z=255 (S=195075): floor → 441, round → 442, exact=0. Repeat with mode_3d=0 and z=255 → 360/361, confirming z is ignored.
- Boundaries, W=8:
  - x=y=0 → root=0, exact=1.
  - x=y=1, round_en=1 → root=1 (rem=1, not > 1), exact=0.
  - 2-D x=0, y=255 → root=255, exact=1.
- Handshakes:
  - Hold out_ready=0 for 6 cycles after out_valid: root, exact and out_valid stay stable and in_ready stays 0.
  - Drive in_valid high throughout: the next accept lands on the edge after the completing handshake.
  - Drop ena for 4 cycles mid-CALC: the result is correct and latency grows by exactly 4.
- Pull rst_n low during CALC (i=3): all outputs go to 0 asynchronously and no stale out_valid appears. After release, a fresh 3,4 request → 5.
- Parameter sweep, W=4 and W=12: random operand sets checked against a floor/round integer square-root model. Latency is W+2.
